// File: rtl/evb_pkg.sv
// Shared constants for the evaluation-block loader: opcodes, degree limit,
// FSM state encoding and a constant-foldable log2 helper.
package evb_pkg;

  localparam logic [2:0] OP_LOAD_COEF = 3'b001;
  localparam logic [2:0] OP_EVAL      = 3'b010;
  localparam logic [4:0] MAX_DEGREE   = 5'd10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_N    = 3'd1,
    S_LOAD_COEF = 3'd2,
    S_LOAD_X    = 3'd3,
    S_START     = 3'd4,
    S_WAIT_EVB  = 3'd5
  } state_t;

  function automatic int clog2(input int unsigned value);
    int result;
    int unsigned v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/evb_loader_fsm.sv
// Command-stream loader: decodes LOAD_COEF / EVAL headers, streams payload
// words into the degree, coefficient and x-data RAMs, then launches one evaluation.
module evb_loader_fsm
  import evb_pkg::*;
#(
  parameter int buffer_size = 1024,
  localparam int AW = clog2(buffer_size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en_data,
  output logic [AW-1:0] wr_addr_data,
  output logic [15:0]   wr_data_data,
  output logic          wr_en_S,
  output logic [2:0]    wr_addr_S_vec,
  output logic [3:0]    wr_addr_S_coef,
  output logic [15:0]   wr_data_S,
  output logic          wr_en_N,
  output logic [2:0]    wr_addr_N,
  output logic [4:0]    wr_data_N,
  output logic          start_evb,
  output logic [2:0]    A,
  output logic [4:0]    b,
  output logic [AW-1:0] rd_addr_data,
  input  logic          done_evb,
  output logic          busy,
  output logic          cmd_err
);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_vec,   w_vec_nxt;
  logic [4:0]    r_n,     w_n_nxt;
  logic [2:0]    r_a,     w_a_nxt;
  logic [4:0]    r_b,     w_b_nxt;
  logic [4:0]    r_cnt,   w_cnt_nxt;
  logic [AW-1:0] r_base,  w_base_nxt;
  logic          r_cmd_err, w_cmd_err_nxt;

  logic          w_accept;
  logic [2:0]    w_opcode;

  assign w_opcode = in_data[15:13];
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vec     <= '0;
      r_n       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_base    <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vec     <= w_vec_nxt;
      r_n       <= w_n_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_cnt     <= w_cnt_nxt;
      r_base    <= w_base_nxt;
      r_cmd_err <= w_cmd_err_nxt;
    end
  end

  // Write data/address buses are zeroed unless their enable is set, so a
  // reset or idle cycle never shows stale payload on any output.
  always_comb begin
    w_state_nxt    = r_state;
    w_vec_nxt      = r_vec;
    w_n_nxt        = r_n;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_cnt_nxt      = r_cnt;
    w_base_nxt     = r_base;
    w_cmd_err_nxt  = 1'b0;
    in_ready       = 1'b0;
    wr_en_data     = 1'b0;
    wr_addr_data   = '0;
    wr_data_data   = '0;
    wr_en_S        = 1'b0;
    wr_addr_S_vec  = '0;
    wr_addr_S_coef = '0;
    wr_data_S      = '0;
    wr_en_N        = 1'b0;
    wr_addr_N      = '0;
    wr_data_N      = '0;
    start_evb      = 1'b0;

    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_cnt_nxt = '0;
          if (w_opcode == OP_LOAD_COEF && in_data[4:0] <= MAX_DEGREE) begin
            w_vec_nxt   = in_data[12:10];
            w_n_nxt     = in_data[4:0];
            w_state_nxt = S_LOAD_N;
          end else if (w_opcode == OP_EVAL) begin
            w_a_nxt     = in_data[12:10];
            w_b_nxt     = in_data[4:0];
            w_state_nxt = S_LOAD_X;
          end else begin
            w_cmd_err_nxt = 1'b1;
          end
        end
      end
      S_LOAD_N: begin
        wr_en_N     = 1'b1;
        wr_addr_N   = r_vec;
        wr_data_N   = r_n;
        w_cnt_nxt   = '0;
        w_state_nxt = S_LOAD_COEF;
      end
      S_LOAD_COEF: begin
        in_ready = 1'b1;
        if (w_accept) begin
          wr_en_S        = 1'b1;
          wr_addr_S_vec  = r_vec;
          wr_addr_S_coef = r_cnt[3:0];
          wr_data_S      = in_data;
          if (r_cnt == r_n) w_state_nxt = S_IDLE;
          else              w_cnt_nxt   = r_cnt + 5'd1;
        end
      end
      S_LOAD_X: begin
        in_ready = 1'b1;
        if (w_accept) begin
          wr_en_data   = 1'b1;
          wr_addr_data = r_base + AW'(r_cnt);
          wr_data_data = in_data;
          if (r_cnt == r_b) w_state_nxt = S_START;
          else              w_cnt_nxt   = r_cnt + 5'd1;
        end
      end
      S_START: begin
        start_evb   = 1'b1;
        w_state_nxt = S_WAIT_EVB;
      end
      S_WAIT_EVB: begin
        if (done_evb) begin
          w_base_nxt  = r_base + AW'({1'b0, r_b} + 6'd1);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign A            = r_a;
  assign b            = r_b;
  assign rd_addr_data = r_base;
  assign busy         = (r_state != S_IDLE);
  assign cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_evb_loader_fsm.sv
// Directed bench for evb_loader_fsm: a negedge monitor logs every RAM write,
// start pulse and error pulse; directed command sequences check the logs.
module tb_evb_loader_fsm;

  localparam int BS = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en_data;
  logic [AW-1:0] wr_addr_data;
  logic [15:0]   wr_data_data;
  logic          wr_en_S;
  logic [2:0]    wr_addr_S_vec;
  logic [3:0]    wr_addr_S_coef;
  logic [15:0]   wr_data_S;
  logic          wr_en_N;
  logic [2:0]    wr_addr_N;
  logic [4:0]    wr_data_N;
  logic          start_evb;
  logic [2:0]    A;
  logic [4:0]    b;
  logic [AW-1:0] rd_addr_data;
  logic          done_evb;
  logic          busy;
  logic          cmd_err;

  evb_loader_fsm #(.buffer_size(BS)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en_data(wr_en_data), .wr_addr_data(wr_addr_data), .wr_data_data(wr_data_data),
    .wr_en_S(wr_en_S), .wr_addr_S_vec(wr_addr_S_vec), .wr_addr_S_coef(wr_addr_S_coef),
    .wr_data_S(wr_data_S),
    .wr_en_N(wr_en_N), .wr_addr_N(wr_addr_N), .wr_data_N(wr_data_N),
    .start_evb(start_evb), .A(A), .b(b), .rd_addr_data(rd_addr_data),
    .done_evb(done_evb), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_err    = 0;
  int n_bad    = 0;
  logic [31:0] q_data[$];
  logic [31:0] q_s[$];
  logic [31:0] q_n[$];
  logic [31:0] q_start[$];

  always @(negedge clk) begin
    if (!rst) begin
      if ((wr_en_data || wr_en_S) && !(in_valid && in_ready)) n_bad++;
      if (wr_en_data) q_data.push_back(32'({wr_addr_data, wr_data_data}));
      if (wr_en_S)    q_s.push_back(32'({wr_addr_S_vec, wr_addr_S_coef, wr_data_S}));
      if (wr_en_N)    q_n.push_back(32'({wr_addr_N, wr_data_N}));
      if (start_evb)  q_start.push_back(32'({A, b, rd_addr_data}));
      if (cmd_err)    n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hdr(input logic [2:0] op, input logic [2:0] f, input logic [4:0] n);
    return {op, f, 5'b0, n};
  endfunction

  function automatic logic [31:0] dent(input int addr, input logic [15:0] d);
    logic [AW-1:0] a;
    a = AW'(addr % BS);
    return 32'({a, d});
  endfunction

  function automatic logic [31:0] sent(input logic [2:0] v, input logic [3:0] c, input logic [15:0] d);
    return 32'({v, c, d});
  endfunction

  function automatic logic [31:0] stent(input logic [2:0] a, input logic [4:0] bb, input int rd);
    logic [AW-1:0] r;
    r = AW'(rd);
    return 32'({a, bb, r});
  endfunction

  task automatic clear_logs();
    q_data.delete(); q_s.delete(); q_n.delete(); q_start.delete();
    n_err = 0;
  endtask

  // Presents one word; returns at the negedge before the edge that takes it.
  task automatic send(input logic [15:0] w);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      if (start_evb) return;
      @(negedge clk);
    end
    check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; done_evb = 1'b1;
    @(posedge clk); #1; done_evb = 1'b0;
  endtask

  task automatic run_eval(input logic [2:0] a, input logic [4:0] bb, input logic [15:0] x0);
    send(hdr(3'b010, a, bb));
    for (int i = 0; i <= int'(bb); i++) send(x0 + 16'(i));
    idle(1);
    wait_start();
    pulse_done();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; done_evb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({wr_en_data, wr_en_S, wr_en_N, start_evb, cmd_err}), 32'd0);
    check("rst_buses", 32'({wr_data_data, wr_addr_data, wr_data_S, wr_data_N}), 32'd0);
    check("rst_evb", 32'({A, b, rd_addr_data}), 32'd0);
    in_valid = 1'b0; in_data = '0; done_evb = 1'b0;
    rst = 1'b0;
    idle(2);

    // LOAD_COEF vec=3 N=2
    clear_logs();
    send(16'h2C02);
    send(16'h0011); send(16'h0022); send(16'h0033);
    idle(3);
    check("lc_n_cnt", 32'(q_n.size()), 32'd1);
    if (q_n.size() > 0) check("lc_n_ent", q_n[0], 32'({3'd3, 5'd2}));
    check("lc_s_cnt", 32'(q_s.size()), 32'd3);
    if (q_s.size() == 3) begin
      check("lc_s0", q_s[0], sent(3, 0, 16'h0011));
      check("lc_s1", q_s[1], sent(3, 1, 16'h0022));
      check("lc_s2", q_s[2], sent(3, 2, 16'h0033));
    end
    check("lc_idle", 32'(busy), 32'd0);
    check("lc_nodata", 32'(q_data.size() + q_start.size()), 32'd0);

    // EVAL A=1 b=3 from base 0
    clear_logs();
    send(16'h4403);
    for (int i = 1; i <= 4; i++) send(16'(i));
    idle(1);
    wait_start();
    repeat (3) @(negedge clk);
    check("ev_ready_low", 32'(in_ready), 32'd0);
    check("ev_busy", 32'(busy), 32'd1);
    check("ev_hold", 32'({A, b, rd_addr_data}), stent(1, 3, 0));
    pulse_done();
    idle(2);
    check("ev_start_cnt", 32'(q_start.size()), 32'd1);
    if (q_start.size() > 0) check("ev_start", q_start[0], stent(1, 3, 0));
    check("ev_d_cnt", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_data.size(); i++)
      check($sformatf("ev_d%0d", i), q_data[i], dent(i, 16'(i + 1)));
    clear_logs();
    run_eval(3'd2, 5'd0, 16'h0055);
    idle(1);
    check("ev2_d", q_data.size() > 0 ? q_data[0] : 32'hDEAD, dent(4, 16'h0055));
    check("ev2_start", q_start.size() > 0 ? q_start[0] : 32'hDEAD, stent(2, 0, 4));

    // Illegal opcode and out-of-range degrees, then a legal N=0 load
    clear_logs();
    send(16'hE000); idle(3);
    check("err_op_pulse", 32'(n_err), 32'd1);
    send(16'h200C); idle(3);
    check("err_n12_pulse", 32'(n_err), 32'd2);
    send(16'h200B); idle(3);
    check("err_n11_pulse", 32'(n_err), 32'd3);
    check("err_nowr", 32'(q_data.size() + q_s.size() + q_n.size() + q_start.size()), 32'd0);
    check("err_idle", 32'(busy), 32'd0);
    send(16'h2400); send(16'hABCD); idle(3);
    check("n0_n", q_n.size() == 1 ? q_n[0] : 32'hDEAD, 32'({3'd1, 5'd0}));
    check("n0_s", q_s.size() == 1 ? q_s[0] : 32'hDEAD, sent(1, 0, 16'hABCD));
    check("n0_noerr", 32'(n_err), 32'd3);

    // N=10 is the largest legal degree
    clear_logs();
    send(16'h3C0A);
    for (int i = 0; i <= 10; i++) send(16'h0100 + 16'(i));
    idle(3);
    check("n10_s_cnt", 32'(q_s.size()), 32'd11);
    check("n10_last", q_s.size() == 11 ? q_s[10] : 32'hDEAD, sent(7, 10, 16'h010A));
    check("n10_noerr", 32'(n_err), 32'd0);

    // done_evb in IDLE/LOAD_X ignored; 5-cycle gap mid LOAD_X at base 5
    clear_logs();
    pulse_done();
    send(16'h4C03);
    send(16'h0A00); send(16'h0A01);
    idle(3);
    done_evb = 1'b1;
    idle(2);
    done_evb = 1'b0;
    check("gap_nowr", 32'(q_data.size()), 32'd2);
    send(16'h0A02); send(16'h0A03);
    idle(1);
    wait_start();
    pulse_done();
    idle(1);
    check("gap_d_cnt", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_data.size(); i++)
      check($sformatf("gap_d%0d", i), q_data[i], dent(5 + i, 16'h0A00 + 16'(i)));
    check("gap_start", q_start.size() == 1 ? q_start[0] : 32'hDEAD, stent(3, 3, 5));

    // Reset after 2 of 4 x words
    clear_logs();
    send(16'h4403); send(16'h0B00); send(16'h0B01);
    @(posedge clk); #2;
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("rr_outs", 32'({wr_en_data, wr_en_S, wr_en_N, start_evb, cmd_err, busy}), 32'd0);
    check("rr_evb", 32'({A, b, rd_addr_data}), 32'd0);
    check("rr_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("rr_nostart", 32'(q_start.size()), 32'd0);
    check("rr_d_cnt", 32'(q_data.size()), 32'd2);
    clear_logs();
    run_eval(3'd0, 5'd0, 16'h0C00);
    idle(1);
    check("rr_fresh", q_data.size() == 1 ? q_data[0] : 32'hDEAD, dent(0, 16'h0C00));

    // Step base 1 -> 1000, then wrap with b=31
    for (int k = 0; k < 31; k++) run_eval(3'd0, 5'd31, 16'h0000);
    run_eval(3'd0, 5'd6, 16'h0000);
    idle(1);
    clear_logs();
    run_eval(3'd5, 5'd31, 16'h1000);
    idle(1);
    check("wr_start", q_start.size() == 1 ? q_start[0] : 32'hDEAD, stent(5, 31, 1000));
    check("wr_d_cnt", 32'(q_data.size()), 32'd32);
    for (int i = 0; i < 32 && i < q_data.size(); i++)
      check($sformatf("wr_d%0d", i), q_data[i], dent(1000 + i, 16'h1000 + 16'(i)));
    clear_logs();
    run_eval(3'd0, 5'd0, 16'h2000);
    idle(1);
    check("wr_next", q_start.size() == 1 ? q_start[0] : 32'hDEAD, stent(0, 0, 8));

    check("no_stray_writes", 32'(n_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/evb_loader_fsm.md
EVB_LOADER_FSM -- requirements
Module: evb_loader_fsm

Interface
REQ-001 SHALL have parameter buffer_size, default 1024, the data buffer depth in words; AW = log2(buffer_size).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports in_data  input  16 (command/payload word), in_valid  input  1, in_ready  output  1.
REQ-005 SHALL have ports wr_en_data  output  1, wr_addr_data  output  AW, wr_data_data  output  16, for x-value writes into the data buffer.
REQ-006 SHALL have ports wr_en_S  output  1, wr_addr_S_vec  output  3, wr_addr_S_coef  output  4, wr_data_S  output  16, for coefficient writes.
REQ-007 SHALL have ports wr_en_N  output  1, wr_addr_N  output  3, wr_data_N  output  5, for degree writes.
REQ-008 SHALL have ports start_evb  output  1, A  output  3, b  output  5, rd_addr_data  output  AW, which launch one block evaluation.
REQ-009 SHALL have ports done_evb  input  1 (evaluator completion pulse), busy  output  1, cmd_err  output  1 (one-cycle error pulse).

Function
REQ-010 SHALL transfer a word only in a cycle where in_valid and in_ready are both 1.
REQ-011 SHALL decode header opcode in_data[15:13]: 001 = LOAD_COEF, 010 = EVAL; any other value is illegal.
REQ-012 LOAD_COEF header: field vec = in_data[12:10], field N = in_data[4:0]. It SHALL be followed by N+1 coefficient words.
REQ-013 EVAL header: field A = in_data[12:10], field b = in_data[4:0]. It SHALL be followed by b+1 x words.
REQ-014 SHALL implement the states IDLE, LOAD_N, LOAD_COEF, LOAD_X, START, WAIT_EVB.
REQ-015 IDLE: in_ready=1. Transitions on an accepted header:
- LOAD_COEF header with N<=10 -> LOAD_N.
- EVAL header -> LOAD_X.
- Illegal opcode, or N>10 -> stay in IDLE, pulse cmd_err for 1 cycle, write nothing.
REQ-016 LOAD_N: in_ready=0. Asserts wr_en_N=1 for exactly one cycle with wr_addr_N=vec and wr_data_N=N, clears the coefficient counter, then goes to LOAD_COEF.
REQ-017 LOAD_COEF: in_ready=1. Each accepted word produces, combinationally in the same cycle:
- wr_en_S=1, wr_addr_S_vec=vec, wr_addr_S_coef=counter, wr_data_S=in_data.
- After the word with counter==N is accepted: return to IDLE.
REQ-018 LOAD_X: in_ready=1. Each accepted word produces, in the same cycle:
- wr_en_data=1, wr_data_data=in_data, wr_addr_data=(base+counter) mod buffer_size.
- After the word with counter==b is accepted: go to START.
REQ-019 START: start_evb=1 for exactly one cycle; rd_addr_data=base; A and b hold the latched header fields. Then go to WAIT_EVB.
REQ-020 WAIT_EVB: in_ready=0. On done_evb=1: base <= (base+b+1) mod buffer_size, then go to IDLE.
REQ-021 A, b and rd_addr_data SHALL remain stable from START until done_evb is received.
REQ-022 All write enables SHALL be 0 whenever no word is accepted in the current cycle; in_valid=0 mid-payload stalls the FSM with no write and no state change.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 done_evb SHALL be ignored in every state except WAIT_EVB.
REQ-025 N=0 or b=0 SHALL load exactly one payload word.

Reset
REQ-026 While rst=1 the block SHALL be in IDLE with base=0 and counter=0.
REQ-027 While rst=1 all outputs SHALL be 0, except in_ready=1.
REQ-028 Reset asserted mid-payload SHALL abandon the command; data already written remains in the RAMs, and no start_evb is issued.

Structure
REQ-029 Opcode values, state encodings and the maximum degree (10) SHALL be constants in a shared package, evb_pkg.
REQ-030 The block SHALL be a single module with no sub-module; log2 comes from the shared function.

Verification
REQ-031 LOAD_COEF vec=3, N=2, payload 0x0011/0x0022/0x0033:
- wr_en_N once with addr=3, data=2.
- Three S writes: (3,0,0x0011), (3,1,0x0022), (3,2,0x0033).
- Ends in IDLE.
REQ-032 EVAL A=1, b=3 from reset, x=1..4:
- Data writes at addresses 0..3.
- One start_evb pulse with rd_addr_data=0, A=1, b=3.
- in_ready=0 until done_evb; the next EVAL then uses base 4.
REQ-033 Repeated EVAL b=31 commands starting from base=1000: data writes wrap 1000..1023 then 0..7; the next base is 8.
REQ-034 Opcode 111, or LOAD_COEF with N=12:
- Single cmd_err pulse, no writes.
- Next valid header accepted normally.
REQ-035 in_valid deasserted for 5 cycles mid-LOAD_X: no writes and no counter advance during the gap; the final write addresses are unchanged.
REQ-036 rst asserted after 2 of 4 x words:
- No start_evb; outputs at reset values.
- A fresh EVAL writes from address 0.
